// File: rtl/sar_adc_pkg.sv
// Shared constants and state encoding for the SAR ADC controller.
package sar_adc_pkg;

   localparam int unsigned DefWidth   = 12;
   localparam int unsigned DefNch     = 4;
   localparam int unsigned DefSettle  = 2;
   localparam int unsigned DefTimeout = 16;

   localparam int unsigned StateW = 3;

   typedef enum logic [StateW-1:0] {
      StIdle   = 3'd0,
      StSample = 3'd1,
      StTrial  = 3'd2,
      StWait   = 3'd3,
      StDone   = 3'd4
   } sar_state_e;

endpackage

// File: rtl/sar_ch_scan.sv
// Lowest-set-bit finder over a channel mask: next channel index plus empty flag.
module sar_ch_scan
   import sar_adc_pkg::*;
#(
   parameter int unsigned NCH  = DefNch,
   parameter int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0]  mask_i,
   output logic [CH_W-1:0] idx_o,
   output logic            empty_o
);

   // Walk from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      for (int k = int'(NCH) - 1; k >= 0; k--) begin
         if (mask_i[k]) idx_o = CH_W'(k);
      end
   end

   assign empty_o = ~|mask_i;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Multi-channel successive-approximation ADC controller.
// Optional feature: define SAR_TIMEOUT_EN to abort a scan when the comparator
// fails to answer within TIMEOUT WAIT cycles (sets the sticky err flag).
module sar_adc_ctrl
   import sar_adc_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned NCH     = DefNch,
   parameter int unsigned SETTLE  = DefSettle,
   parameter int unsigned TIMEOUT = DefTimeout,
   parameter int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             st_conv_i,
   input  logic [NCH-1:0]   ch_mask_i,
   input  logic             comp_out_i,
   input  logic             comp_done_i,
   output logic             comp_start_o,
   output logic [WIDTH-1:0] dac_code_o,
   output logic [CH_W-1:0]  ch_sel_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] data_out_o,
   output logic [CH_W-1:0]  data_ch_o,
   output logic             data_valid_o,
   output logic             err_o
);

   localparam int unsigned IW = $clog2(WIDTH);

   sar_state_e       state_q, state_d;
   logic [NCH-1:0]   mask_q, mask_d;
   logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IW-1:0]    bit_q, bit_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] dac_q, dac_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CH_W-1:0]  data_ch_q, data_ch_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic [NCH-1:0]   done_bit;
   logic [NCH-1:0]   scan_mask;
   logic [CH_W-1:0]  scan_idx;
   logic             scan_empty;

   // One-hot of the channel being converted, used to retire it from the mask.
   always_comb begin
      done_bit = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         done_bit[k] = (ch_sel_q == CH_W'(k));
      end
   end

   // In IDLE the scanner looks at the request; otherwise at the remaining channels.
   assign scan_mask = (state_q == StIdle) ? ch_mask_i : (mask_q & ~done_bit);

   sar_ch_scan #(
      .NCH  (NCH),
      .CH_W (CH_W)
   ) u_scan (
      .mask_i  (scan_mask),
      .idx_o   (scan_idx),
      .empty_o (scan_empty)
   );

   // Next-state logic for the scan/convert FSM and its datapath registers.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      ch_sel_d  = ch_sel_q;
      busy_d    = busy_q;
      result_d  = result_q;
      bit_d     = bit_q;
      cnt_d     = cnt_q;
      dac_d     = dac_q;
      data_d    = data_q;
      data_ch_d = data_ch_q;
      valid_d   = 1'b0;
      err_d     = err_q;
      unique case (state_q)
         StIdle: begin
            if (st_conv_i && !scan_empty) begin
               mask_d   = ch_mask_i;
               ch_sel_d = scan_idx;
               busy_d   = 1'b1;
               err_d    = 1'b0;
               cnt_d    = '0;
               dac_d    = '0;
               result_d = '0;
               state_d  = StSample;
            end
         end
         StSample: begin
            if (cnt_q == 16'(SETTLE - 1)) begin
               bit_d   = IW'(WIDTH - 1);
               dac_d   = {1'b1, {(WIDTH-1){1'b0}}};
               state_d = StTrial;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StTrial: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (comp_done_i) begin
               result_d[bit_q] = comp_out_i;
               if (bit_q == '0) begin
                  data_d    = result_d;
                  data_ch_d = ch_sel_q;
                  valid_d   = 1'b1;
                  state_d   = StDone;
               end else begin
                  bit_d   = bit_q - 1'b1;
                  dac_d   = result_d | (WIDTH'(1) << bit_d);
                  state_d = StTrial;
               end
            end
`ifdef SAR_TIMEOUT_EN
            else if (cnt_q == 16'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         StDone: begin
            mask_d = scan_mask;
            if (scan_empty) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               ch_sel_d = scan_idx;
               cnt_d    = '0;
               dac_d    = '0;
               result_d = '0;
               state_d  = StSample;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         mask_q    <= '0;
         ch_sel_q  <= '0;
         busy_q    <= 1'b0;
         result_q  <= '0;
         bit_q     <= '0;
         cnt_q     <= '0;
         dac_q     <= '0;
         data_q    <= '0;
         data_ch_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         ch_sel_q  <= ch_sel_d;
         busy_q    <= busy_d;
         result_q  <= result_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         dac_q     <= dac_d;
         data_q    <= data_d;
         data_ch_q <= data_ch_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign comp_start_o = (state_q == StTrial);
   assign dac_code_o   = dac_q;
   assign ch_sel_o     = ch_sel_q;
   assign busy_o       = busy_q;
   assign data_out_o   = data_q;
   assign data_ch_o    = data_ch_q;
   assign data_valid_o = valid_q;

`ifdef SAR_TIMEOUT_EN
   assign err_o = err_q;
`else
   // Without the timeout the flag can never be set.
   logic unused_timeout;
   assign unused_timeout = ^{TIMEOUT, err_q};
   assign err_o = 1'b0;
`endif

endmodule
